// File: rtl/lsu_pkg.sv
// lsu_pkg
// Shared definitions for the load/store unit: FSM state encoding, load/store
// size encodings, default bus timeout and small address helpers.
// Used by load_store_unit and lsu_align.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_t;

  // Access size encodings; any size with bit 1 set is a word.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Default number of cycles to wait for a bus ack before aborting.
  localparam int LSU_TIMEOUT_DEFAULT = 16;

  // True when the low address bits do not suit the access size.
  function automatic logic lsu_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    logic result;
    case (size)
      SIZE_BYTE: result = 1'b0;
      SIZE_HALF: result = addr_lo[0];
      default:   result = |addr_lo;
    endcase
    return result;
  endfunction

  // Clears the low address bits a given size cannot use.
  function automatic logic [1:0] lsu_align_lo(input logic [1:0] size,
                                              input logic [1:0] addr_lo);
    logic [1:0] result;
    case (size)
      SIZE_BYTE: result = addr_lo;
      SIZE_HALF: result = {addr_lo[1], 1'b0};
      default:   result = 2'b00;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align
// Purely combinational lane logic for the load/store unit.
// Store side: byte strobes and lane-replicated write data from size + addr_lo.
// Load side: picks the byte/half lane out of the bus word and sign- or
// zero-extends it.
// Ports:
//   i_size      access size (00 byte, 01 half, 1x word)
//   i_addr_lo   address bits [1:0] (already aligned to the size)
//   i_unsigned  1 = zero-extend loads
//   i_wdata     store data, LSB-aligned
//   i_rdata     raw bus read word
//   o_mask      byte strobes
//   o_wdata     store data placed in its lanes
//   o_ldata     extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_mask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store strobes and data: narrow data is replicated across the word so the
  // selected lanes always carry it regardless of offset.
  always_comb begin
    o_mask  = 4'b1111;
    o_wdata = i_wdata;
    case (i_size)
      SIZE_BYTE: begin
        o_mask  = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SIZE_HALF: begin
        o_mask  = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_mask  = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase
  end

  // Load lane selection and extension.
  always_comb begin
    w_byte  = i_rdata[7:0];
    w_half  = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_ldata = i_rdata;
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    case (i_size)
      SIZE_BYTE: o_ldata = i_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SIZE_HALF: o_ldata = i_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      default:   o_ldata = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
// Single-outstanding load/store unit bridging a request port to a simple
// word-wide data bus with byte strobes, with an ack timeout.
// FSM: IDLE -> ACCESS -> RESP -> IDLE. Requests are accepted only in IDLE.
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   - misaligned half/word requests skip the bus and respond with
//               rsp_err_out = 1
//   undefined - misaligned low address bits are cleared and the access runs
// Ports:
//   clk_in, rst_in                 clock, async active-high reset
//   req_valid_in / req_ready_out   request handshake
//   mem_wr_req_in, load_size_in, load_unsigned_in, addr_in, wdata_in,
//   rd_addr_in                     request fields
//   dbus_*                         data bus (held stable until ack)
//   rsp_valid_out, rsp_data_out, rsp_rd_addr_out, rsp_err_out
//                                  one-cycle completion
//   busy_out                       state is not IDLE
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic        mem_wr_req_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic [4:0]  rd_addr_in,
  output logic [31:0] dbus_addr_out,
  output logic [31:0] dbus_wdata_out,
  output logic [3:0]  dbus_wr_mask_out,
  output logic        dbus_wr_req_out,
  output logic        dbus_rd_req_out,
  input  logic        dbus_ack_in,
  input  logic [31:0] dbus_rdata_in,
  output logic        rsp_valid_out,
  output logic [31:0] rsp_data_out,
  output logic [4:0]  rsp_rd_addr_out,
  output logic        rsp_err_out,
  output logic        busy_out
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t r_state;
  lsu_state_t w_state_next;

  logic             r_wr;
  logic             r_unsigned;
  logic [1:0]       r_size;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [4:0]       r_tag;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_rsp_data;
  logic             r_rsp_err;

  logic        w_accept;
  logic        w_trap;
  logic        w_timeout;
  logic        w_access;
  logic        w_resp;
  logic [3:0]  w_mask;
  logic [31:0] w_wdata_lane;
  logic [31:0] w_load_data;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = lsu_misaligned(load_size_in, addr_in[1:0]);
`else
  assign w_trap = 1'b0;
`endif

  // The last allowed ACCESS cycle; an ack in this same cycle still wins.
  assign w_timeout = (r_count == CNT_LAST);

  lsu_align u_align (
    .i_size     (r_size),
    .i_addr_lo  (r_addr[1:0]),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata),
    .i_rdata    (dbus_rdata_in),
    .o_mask     (w_mask),
    .o_wdata    (w_wdata_lane),
    .o_ldata    (w_load_data)
  );

  // State register; reset drops any bus request immediately because all bus
  // outputs are decoded from the state.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and state-decoded control outputs.
  always_comb begin
    w_state_next  = r_state;
    req_ready_out = 1'b0;
    busy_out      = 1'b1;
    w_access      = 1'b0;
    w_resp        = 1'b0;
    w_accept      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready_out = 1'b1;
        busy_out      = 1'b0;
        w_accept      = req_valid_in;
        if (req_valid_in) begin
          w_state_next = w_trap ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_access = 1'b1;
        if (dbus_ack_in || w_timeout) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        w_resp       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Request capture, access-cycle counting and response formation.
  // Misaligned low address bits are cleared at capture so the bus only ever
  // sees a size-aligned offset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr       <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= SIZE_BYTE;
      r_addr     <= 32'b0;
      r_wdata    <= 32'b0;
      r_tag      <= 5'b0;
      r_count    <= '0;
      r_rsp_data <= 32'b0;
      r_rsp_err  <= 1'b0;
    end else if (w_accept) begin
      r_wr       <= mem_wr_req_in;
      r_unsigned <= load_unsigned_in;
      r_size     <= load_size_in;
      r_addr     <= {addr_in[31:2], lsu_align_lo(load_size_in, addr_in[1:0])};
      r_wdata    <= wdata_in;
      r_tag      <= rd_addr_in;
      r_count    <= '0;
      r_rsp_data <= 32'b0;
      r_rsp_err  <= w_trap;
    end else if (w_access) begin
      r_count <= r_count + CNT_W'(1);
      if (dbus_ack_in) begin
        r_rsp_data <= r_wr ? 32'b0 : w_load_data;
        r_rsp_err  <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_data <= 32'b0;
        r_rsp_err  <= 1'b1;
      end
    end
  end

  assign dbus_addr_out    = w_access ? {r_addr[31:2], 2'b00} : 32'b0;
  assign dbus_wdata_out   = (w_access && r_wr) ? w_wdata_lane : 32'b0;
  assign dbus_wr_mask_out = (w_access && r_wr) ? w_mask : 4'b0;
  assign dbus_wr_req_out  = w_access && r_wr;
  assign dbus_rd_req_out  = w_access && !r_wr;

  assign rsp_valid_out   = w_resp;
  assign rsp_data_out    = w_resp ? r_rsp_data : 32'b0;
  assign rsp_rd_addr_out = w_resp ? r_tag : 5'b0;
  assign rsp_err_out     = w_resp && r_rsp_err;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Scoreboard bench for load_store_unit: each request pushes its expected bus
// behaviour and response; a monitor checks bus activity and pops/compares on
// every response pulse.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int TO = 16;

  logic        clock;
  logic        reset;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        mem_wr_req_in;
  logic [1:0]  load_size_in;
  logic        load_unsigned_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic [4:0]  rd_addr_in;
  logic [31:0] dbus_addr_out;
  logic [31:0] dbus_wdata_out;
  logic [3:0]  dbus_wr_mask_out;
  logic        dbus_wr_req_out;
  logic        dbus_rd_req_out;
  logic        dbus_ack_in;
  logic [31:0] dbus_rdata_in;
  logic        rsp_valid_out;
  logic [31:0] rsp_data_out;
  logic [4:0]  rsp_rd_addr_out;
  logic        rsp_err_out;
  logic        busy_out;

  typedef struct {
    logic        busExp;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] data;
    logic        err;
    logic [4:0]  tag;
    int          busCycles;
    logic        acked;
  } expTxn_t;

  expTxn_t expQ[$];
  expTxn_t monCur;
  int      testsRun;
  int      failures;
  int      busCycles;
  int      rspSeen;
  logic    prevValid;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_in           (clock),
    .rst_in           (reset),
    .req_valid_in     (req_valid_in),
    .req_ready_out    (req_ready_out),
    .mem_wr_req_in    (mem_wr_req_in),
    .load_size_in     (load_size_in),
    .load_unsigned_in (load_unsigned_in),
    .addr_in          (addr_in),
    .wdata_in         (wdata_in),
    .rd_addr_in       (rd_addr_in),
    .dbus_addr_out    (dbus_addr_out),
    .dbus_wdata_out   (dbus_wdata_out),
    .dbus_wr_mask_out (dbus_wr_mask_out),
    .dbus_wr_req_out  (dbus_wr_req_out),
    .dbus_rd_req_out  (dbus_rd_req_out),
    .dbus_ack_in      (dbus_ack_in),
    .dbus_rdata_in    (dbus_rdata_in),
    .rsp_valid_out    (rsp_valid_out),
    .rsp_data_out     (rsp_data_out),
    .rsp_rd_addr_out  (rsp_rd_addr_out),
    .rsp_err_out      (rsp_err_out),
    .busy_out         (busy_out)
  );

  // Free-running clock, 10 time units per cycle.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point; every check is counted here.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Reference model of one transaction, written from the bus-protocol view.
  function automatic expTxn_t modelTxn(input logic wr, input logic [1:0] size,
                                       input logic uns, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [4:0] tag,
                                       input int ackDelay, input logic [31:0] rdata);
    expTxn_t t;
    logic [1:0]  lo;
    logic [31:0] lane;
    logic        bad;
    lo   = addr[1:0];
    bad  = (size == 2'b01 && lo[0]) || (size[1] && lo != 2'b00);
    if (size == 2'b01) lo[0] = 1'b0;
    if (size[1]) lo = 2'b00;
    t.wr        = wr;
    t.tag       = tag;
    t.addr      = {addr[31:2], 2'b00};
    t.busExp    = 1'b1;
    t.busCycles = 0;
    t.acked     = 1'b0;
    t.data      = 32'h0;
    t.err       = 1'b0;
    if (size == 2'b00) begin
      t.mask  = 4'b0001 << lo;
      t.wdata = {24'h0, wdata[7:0]} << (8 * lo);
    end else if (size == 2'b01) begin
      t.mask  = lo[1] ? 4'b1100 : 4'b0011;
      t.wdata = {16'h0, wdata[15:0]} << (16 * lo[1]);
    end else begin
      t.mask  = 4'b1111;
      t.wdata = wdata;
    end
`ifdef LSU_MISALIGN_TRAP_EN
    if (bad) begin
      t.busExp = 1'b0;
      t.err    = 1'b1;
      return t;
    end
`else
    if (bad) t.err = 1'b0;
`endif
    if (ackDelay < 0 || ackDelay >= TO) begin
      t.busCycles = TO;
      t.err       = 1'b1;
    end else begin
      t.busCycles = ackDelay + 1;
      t.acked     = 1'b1;
      lane        = rdata >> (8 * lo);
      if (!wr) begin
        if (size == 2'b00)      t.data = uns ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
        else if (size == 2'b01) t.data = uns ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
        else                    t.data = rdata;
      end
    end
    return t;
  endfunction

  // Drives one request, then plays the bus slave: ack after ackDelay ACCESS
  // cycles (negative = never). A stray request is offered while busy.
  task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [4:0] tag, input int ackDelay,
                               input logic [31:0] rdata);
    int cyc;
    int startRsp;
    bit seen;
    expQ.push_back(modelTxn(wr, size, uns, addr, wdata, tag, ackDelay, rdata));
    @(negedge clock);
    checkOutput("readyIdle", req_ready_out, 1);
    mem_wr_req_in    = wr;
    load_size_in     = size;
    load_unsigned_in = uns;
    addr_in          = addr;
    wdata_in         = wdata;
    rd_addr_in       = tag;
    req_valid_in     = 1'b1;
    startRsp         = rspSeen;
    @(negedge clock);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 40) begin
      if (cyc == 0) begin
        checkOutput("readyBusy", req_ready_out, 0);
        checkOutput("busyFlag", busy_out, 1);
        req_valid_in  = 1'b1;
        mem_wr_req_in = ~wr;
        addr_in       = 32'hFFFF_FFFC;
        wdata_in      = $urandom;
        rd_addr_in    = ~tag;
      end else begin
        req_valid_in = 1'b0;
      end
      dbus_ack_in   = (ackDelay >= 0 && cyc == ackDelay);
      dbus_rdata_in = dbus_ack_in ? rdata : $urandom;
      @(negedge clock);
      cyc++;
      seen = (rspSeen != startRsp);
    end
    req_valid_in = 1'b0;
    dbus_ack_in  = 1'b0;
    if (!seen) checkOutput("rspTimeout", 0, 1);
  endtask

  // Monitor: checks every bus-request cycle against the head of the
  // scoreboard and pops it on each response pulse.
  always @(posedge clock) begin
    #1;
    if (reset) begin
      prevValid = 1'b0;
    end else begin
      if (dbus_rd_req_out || dbus_wr_req_out) begin
        if (expQ.size() == 0) begin
          checkOutput("busUnexpected", 1, 0);
        end else begin
          monCur = expQ[0];
          checkOutput("busIssued", 1, {31'b0, monCur.busExp});
          checkOutput("busAddr", dbus_addr_out, monCur.addr);
          checkOutput("busWrReq", dbus_wr_req_out, monCur.wr);
          checkOutput("busRdReq", dbus_rd_req_out, !monCur.wr);
          if (monCur.wr) begin
            checkOutput("busMask", dbus_wr_mask_out, monCur.mask);
            checkOutput("busWdata",
                        dbus_wdata_out & {{8{monCur.mask[3]}}, {8{monCur.mask[2]}},
                                          {8{monCur.mask[1]}}, {8{monCur.mask[0]}}},
                        monCur.wdata);
          end
          busCycles++;
        end
      end
      if (prevValid) checkOutput("rspPulse", rsp_valid_out, 0);
      if (rsp_valid_out && !prevValid) begin
        if (expQ.size() == 0) begin
          checkOutput("rspUnexpected", 1, 0);
        end else begin
          monCur = expQ.pop_front();
          checkOutput("rspData", rsp_data_out, monCur.data);
          checkOutput("rspErr", rsp_err_out, monCur.err);
          checkOutput("rspTag", rsp_rd_addr_out, monCur.tag);
          checkOutput("busCycles", busCycles, monCur.busCycles);
          if (monCur.acked) checkOutput("rspAfterAck", dbus_ack_in, 1);
        end
        busCycles = 0;
        rspSeen++;
      end
      prevValid = rsp_valid_out;
    end
  end

  // Reset asserted mid-ACCESS: bus request must vanish at once and a late
  // ack must not produce a response.
  task automatic resetMidAccess();
    expQ.push_back(modelTxn(1'b0, SIZE_WORD, 1'b0, 32'h0000_6000, 32'h0, 5'd9, -1, 32'h0));
    @(negedge clock);
    mem_wr_req_in    = 1'b0;
    load_size_in     = SIZE_WORD;
    load_unsigned_in = 1'b0;
    addr_in          = 32'h0000_6000;
    rd_addr_in       = 5'd9;
    req_valid_in     = 1'b1;
    @(negedge clock);
    req_valid_in = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("rstPreReq", dbus_rd_req_out, 1);
    reset = 1'b1;
    #1;
    checkOutput("rstRdReq", dbus_rd_req_out, 0);
    checkOutput("rstReady", req_ready_out, 1);
    checkOutput("rstBusy", busy_out, 0);
    checkOutput("rstRspValid", rsp_valid_out, 0);
    expQ.delete();
    busCycles = 0;
    @(negedge clock);
    reset         = 1'b0;
    dbus_ack_in   = 1'b1;
    dbus_rdata_in = 32'h1234_5678;
    @(negedge clock);
    dbus_ack_in = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("rstResumeReady", req_ready_out, 1);
    checkOutput("rstResumeBusy", busy_out, 0);
  endtask

  // Ack pulses while IDLE must be ignored.
  task automatic idleAck();
    @(negedge clock);
    dbus_ack_in = 1'b1;
    @(negedge clock);
    dbus_ack_in = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("idleAckBusy", busy_out, 0);
  endtask

  // Main sequence.
  initial begin
    testsRun         = 0;
    failures         = 0;
    busCycles        = 0;
    rspSeen          = 0;
    prevValid        = 1'b0;
    reset            = 1'b1;
    req_valid_in     = 1'b0;
    mem_wr_req_in    = 1'b0;
    load_size_in     = 2'b00;
    load_unsigned_in = 1'b0;
    addr_in          = 32'h0;
    wdata_in         = 32'h0;
    rd_addr_in       = 5'h0;
    dbus_ack_in      = 1'b0;
    dbus_rdata_in    = 32'h0;
    #12;
    checkOutput("resetReady", req_ready_out, 1);
    checkOutput("resetBusy", busy_out, 0);
    checkOutput("resetRdReq", dbus_rd_req_out, 0);
    checkOutput("resetWrReq", dbus_wr_req_out, 0);
    checkOutput("resetRspValid", rsp_valid_out, 0);
    checkOutput("resetRspData", rsp_data_out, 0);
    @(negedge clock);
    reset = 1'b0;

    applyStimulus(1'b0, SIZE_BYTE, 1'b0, 32'h0000_1003, 32'h0, 5'd3, 1, 32'h80AB_CDEF);
    applyStimulus(1'b1, SIZE_HALF, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 5'd4, 0, 32'h0);
    applyStimulus(1'b0, SIZE_BYTE, 1'b1, 32'h0000_1001, 32'h0, 5'd5, 2, 32'h12F0_ABCD);
    applyStimulus(1'b0, SIZE_HALF, 1'b0, 32'h0000_2002, 32'h0, 5'd6, 0, 32'h8001_1234);
    applyStimulus(1'b0, SIZE_HALF, 1'b1, 32'h0000_2000, 32'h0, 5'd7, 3, 32'h8001_F234);
    applyStimulus(1'b1, SIZE_BYTE, 1'b0, 32'h0000_4001, 32'h0000_00A5, 5'd8, 1, 32'h0);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h0000_5000, 32'hCAFE_F00D, 5'd10, 0, 32'h0);
    applyStimulus(1'b0, SIZE_WORD, 1'b0, 32'h0000_7000, 32'h0, 5'd11, -1, 32'h0);
    applyStimulus(1'b0, SIZE_WORD, 1'b0, 32'h0000_7004, 32'h0, 5'd12, TO - 1, 32'h5A5A_A5A5);
    applyStimulus(1'b0, SIZE_WORD, 1'b0, 32'h0000_3002, 32'h0, 5'd13, 1, 32'hDEAD_BEEF);
    idleAck();
    resetMidAccess();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), $urandom, $urandom,
                    5'($urandom_range(0, 31)), $urandom_range(0, 4), $urandom);
    end

    repeat (3) @(negedge clock);
    checkOutput("queueEmpty", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

  // Hard stop if the sequence ever wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got 0 expected 1");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
